// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin burst drain from NUM_SRC source FIFOs into one destination FIFO
module fifo_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_BITS  = 8,
    parameter int BURST_BITS = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         en_i,
    input  logic [BURST_BITS-1:0]        burst_len_i,
    input  logic [NUM_SRC-1:0]           src_empty_i,
    input  logic [NUM_SRC*DATA_BITS-1:0] src_rd_data_i,
    output logic [NUM_SRC-1:0]           src_rd_en_o,
    input  logic                         dst_full_i,
    output logic                         dst_wr_en_o,
    output logic [DATA_BITS-1:0]         dst_wr_data_o,
    output logic                         grant_vld_o,
    output logic [$clog2(NUM_SRC)-1:0]   grant_idx_o
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = BURST_BITS + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0]   blen_q, blen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     cand;
    logic               sel_empty;
    logic [DATA_BITS-1:0] sel_data;
    logic               xfer;
    logic [IDX_W-1:0]   grant_next;

    // Rotating priority search: first non-empty source at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(NUM_SRC)) begin
                cand = cand - (IDX_W+1)'(NUM_SRC);
            end
            if (!pick_found && !src_empty_i[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_empty = 1'b1;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                sel_empty = src_empty_i[i];
                sel_data  = src_rd_data_i[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign xfer       = !sel_empty && !dst_full_i;
    assign grant_next = (grant_idx_q == IDX_W'(NUM_SRC-1)) ? '0 : grant_idx_q + IDX_W'(1);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_idx_d   = grant_idx_q;
        blen_d        = blen_q;
        cnt_d         = cnt_q;
        src_rd_en_o   = '0;
        dst_wr_en_o   = 1'b0;
        dst_wr_data_o = sel_data;
        grant_vld_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en_i && pick_found) begin
                    grant_idx_d = pick_idx;
                    blen_d      = (burst_len_i == '0) ? {1'b1, {BURST_BITS{1'b0}}}
                                                      : {1'b0, burst_len_i};
                    cnt_d       = '0;
                    state_d     = ST_XFER;
                end
            end
            ST_XFER: begin
                grant_vld_o = 1'b1;
                if (sel_empty) begin
                    // Source ran dry: release without moving a word, even if dst is full.
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_next;
                end else if (xfer) begin
                    src_rd_en_o[grant_idx_q] = 1'b1;
                    dst_wr_en_o              = 1'b1;
                    if (cnt_q == blen_q - CNT_W'(1)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_next;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            blen_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            blen_q      <= blen_d;
            cnt_q       <= cnt_d;
        end
    end

    assign grant_idx_o = grant_idx_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - directed bench for fifo_rr_arbiter with modelled source FIFOs
module tb_fifo_rr_arbiter;

    localparam int NS = 4;
    localparam int DB = 8;
    localparam int BB = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            en;
    logic [BB-1:0]   burst_len;
    logic [NS-1:0]   src_empty;
    logic [NS*DB-1:0] src_rd_data;
    logic [NS-1:0]   src_rd_en;
    logic            dst_full;
    logic            dst_wr_en;
    logic [DB-1:0]   dst_wr_data;
    logic            grant_vld;
    logic [1:0]      grant_idx;

    fifo_rr_arbiter #(.NUM_SRC(NS), .DATA_BITS(DB), .BURST_BITS(BB)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .en_i          (en),
        .burst_len_i   (burst_len),
        .src_empty_i   (src_empty),
        .src_rd_data_i (src_rd_data),
        .src_rd_en_o   (src_rd_en),
        .dst_full_i    (dst_full),
        .dst_wr_en_o   (dst_wr_en),
        .dst_wr_data_o (dst_wr_data),
        .grant_vld_o   (grant_vld),
        .grant_idx_o   (grant_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    logic [7:0] mem [NS][32];
    int         head [NS];
    int         tail [NS];

    logic [7:0] log_data [64];
    int         log_n;
    logic [1:0] glog [32];
    int         glog_n;

    logic          s_wr_en, s_gvld, prev_gvld;
    logic [7:0]    s_wr_data;
    logic [NS-1:0] s_rd_en;
    logic [1:0]    s_gidx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] word(input int s, input int k);
        return 8'((s << 5) | k);
    endfunction

    task automatic refresh();
        for (int i = 0; i < NS; i++) begin
            src_empty[i] = (head[i] == tail[i]);
            src_rd_data[i*DB +: DB] = mem[i][head[i] % 32];
        end
    endtask

    task automatic load(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            mem[s][tail[s]] = word(s, k);
            tail[s]++;
        end
        refresh();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        log_n  = 0;
        glog_n = 0;
        refresh();
    endtask

    // One clock: observe at negedge, then apply the pops the DUT requested.
    task automatic step();
        @(negedge clk);
        s_wr_en   = dst_wr_en;
        s_wr_data = dst_wr_data;
        s_rd_en   = src_rd_en;
        s_gvld    = grant_vld;
        s_gidx    = grant_idx;
        if (dst_wr_en && dst_full) viol++;
        if ($countones(src_rd_en) > 1) viol++;
        if ((src_rd_en != '0) != dst_wr_en) viol++;
        for (int i = 0; i < NS; i++) begin
            if (src_rd_en[i] && src_empty[i]) viol++;
            if (src_rd_en[i] && (grant_idx != 2'(i))) viol++;
        end
        if (dst_wr_en && log_n < 64) begin
            log_data[log_n] = dst_wr_data;
            log_n++;
        end
        if (grant_vld && !prev_gvld && glog_n < 32) begin
            glog[glog_n] = grant_idx;
            glog_n++;
        end
        prev_gvld = grant_vld;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (s_rd_en[i] && head[i] != tail[i]) head[i]++;
        end
        refresh();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic run_drain(input string tag, input int budget);
        logic busy;
        busy = 1'b1;
        for (int c = 0; c < budget && busy; c++) begin
            step();
            busy = s_gvld;
            for (int i = 0; i < NS; i++) if (head[i] != tail[i]) busy = 1'b1;
        end
        chk(tag, 32'(busy), 0);
    endtask

    logic [22:0] tr, tr_exp;

    initial begin
        reset_n = 1'b0; en = 1'b0; burst_len = '0; dst_full = 1'b0;
        prev_gvld = 1'b0;
        clear_all();

        // 1: reset state, then three-word source drained and released on empty
        do_reset();
        chk("rst_wr_en", 32'(s_wr_en), 0);
        chk("rst_rd_en", 32'(s_rd_en), 0);
        chk("rst_gvld", 32'(s_gvld), 0);
        chk("rst_gidx", 32'(s_gidx), 0);
        clear_all();
        mem[0][0] = 8'hA1; mem[0][1] = 8'hB2; mem[0][2] = 8'hC3; tail[0] = 3;
        burst_len = 4'd4; en = 1'b1; refresh();
        step(); chk("t1_idle_wr", 32'(s_wr_en), 0);
        step(); chk("t1_w0_en", 32'(s_wr_en), 1); chk("t1_w0", 32'(s_wr_data), 32'hA1);
        step(); chk("t1_w1_en", 32'(s_wr_en), 1); chk("t1_w1", 32'(s_wr_data), 32'hB2);
        step(); chk("t1_w2_en", 32'(s_wr_en), 1); chk("t1_w2", 32'(s_wr_data), 32'hC3);
        step(); chk("t1_empty_wr", 32'(s_wr_en), 0); chk("t1_empty_gvld", 32'(s_gvld), 1);
        step(); chk("t1_idle_gvld", 32'(s_gvld), 0);
        load(0, 1); load(1, 1);
        step();
        step(); chk("t1_rrptr_gidx", 32'(s_gidx), 1);
        run_drain("t1_drain", 20);

        // 2: four full sources, bursts of 2, strict rotation
        do_reset(); clear_all();
        burst_len = 4'd2; en = 1'b1;
        for (int s = 0; s < NS; s++) load(s, 10);
        run_drain("t2_drain", 200);
        chk("t2_count", 32'(log_n), 40);
        for (int r = 0; r < 5; r++)
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < 2; w++)
                    chk($sformatf("t2_word%0d", r*8+s*2+w), 32'(log_data[r*8+s*2+w]), 32'(word(s, 2*r+w)));
        chk("t2_grants", 32'(glog_n), 20);
        for (int j = 0; j < 20; j++) chk($sformatf("t2_grant%0d", j), 32'(glog[j]), 32'(j % 4));

        // 3: burst_len 0 means 16 words
        do_reset(); clear_all();
        burst_len = 4'd0; en = 1'b1; load(2, 20);
        tr_exp = '0;
        for (int c = 1; c <= 16; c++) tr_exp[c] = 1'b1;
        for (int c = 18; c <= 21; c++) tr_exp[c] = 1'b1;
        for (int c = 0; c < 23; c++) begin
            step();
            tr[c] = s_wr_en;
        end
        chk("t3_trace", 32'(tr), 32'(tr_exp));
        chk("t3_count", 32'(log_n), 20);
        for (int k = 0; k < 20; k++) chk($sformatf("t3_word%0d", k), 32'(log_data[k]), 32'(word(2, k)));

        // 4: destination full for three clocks mid-burst
        do_reset(); clear_all();
        burst_len = 4'd8; en = 1'b1; load(1, 6);
        step(); step(); step();
        dst_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t4_stall_wr", 32'(s_wr_en), 0);
            chk("t4_stall_rd", 32'(s_rd_en), 0);
            chk("t4_stall_gidx", 32'(s_gidx), 1);
            chk("t4_stall_gvld", 32'(s_gvld), 1);
        end
        dst_full = 1'b0;
        run_drain("t4_drain", 30);
        chk("t4_count", 32'(log_n), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("t4_word%0d", k), 32'(log_data[k]), 32'(word(1, k)));

        // 5: en dropped mid-burst; burst completes then arbiter idles
        do_reset(); clear_all();
        burst_len = 4'd8; en = 1'b1;
        for (int s = 0; s < NS; s++) load(s, 12);
        step(); step(); step();
        en = 1'b0;
        for (int c = 0; c < 20; c++) step();
        chk("t5_count", 32'(log_n), 8);
        chk("t5_last", 32'(log_data[7]), 32'(word(0, 7)));
        chk("t5_grants", 32'(glog_n), 1);
        chk("t5_idle_gvld", 32'(s_gvld), 0);
        en = 1'b1;
        step();
        step();
        chk("t5_regrant_gvld", 32'(s_gvld), 1);
        chk("t5_regrant_gidx", 32'(s_gidx), 1);
        chk("t5_regrant_data", 32'(s_wr_data), 32'(word(1, 0)));

        // 6: one-clock reset mid-burst returns priority to source 0
        step(); step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("t6_wr", 32'(s_wr_en), 0);
        chk("t6_rd", 32'(s_rd_en), 0);
        chk("t6_gvld", 32'(s_gvld), 0);
        step();
        chk("t6_gvld2", 32'(s_gvld), 1);
        chk("t6_gidx", 32'(s_gidx), 0);
        chk("t6_data", 32'(s_wr_data), 32'(word(0, 8)));

        chk("protocol", 32'(viol), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
